cpu_debug_host_scan: RTL and testbench

- Host-side (initiator) scan engine for the Nios II CPU debug slave's virtual-JTAG port.
- Takes IR/DR scan commands on the system clock and generates the vji_* sequence the debug slave consumes: tck, tdi, ir_in, and the uir/cdr/sdr/udr/rti strobes.
- Returns the captured tdo data and ir_out on a response handshake.
- Used in the simulation harness and in an on-chip debug master that drives the debug slave without a physical JTAG cable.

---
 rtl/cpu_debug_host_scan_pkg.sv | 29 ++
 rtl/cpu_debug_host_tck_gen.sv | 43 ++++
 rtl/cpu_debug_host_scan.sv | 154 +++++++++++++++
 tb/tb_cpu_debug_host_scan.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_debug_host_scan_pkg.sv
// Shared types and constants for the host-side virtual-JTAG scan engine.
package cpu_debug_host_scan_pkg;

  // Default widths matching the Nios II debug slave's scan chain.
  localparam int DR_W_DEF = 38;
  localparam int IR_W_DEF = 2;

  // Debug-slave virtual IR codes.
  localparam logic [1:0] IR_OCIMEM   = 2'd0;
  localparam logic [1:0] IR_OCIMEM_B = 2'd1;
  localparam logic [1:0] IR_BREAK    = 2'd2;
  localparam logic [1:0] IR_TRACE    = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SDR,
    ST_UDR,
    ST_RTI,
    ST_RSP
  } scan_state_e;

  // The scan clock only runs while a scan is in flight.
  function automatic logic tck_running(input scan_state_e s);
    return !((s == ST_IDLE) || (s == ST_RSP));
  endfunction

endpackage

// File: rtl/cpu_debug_host_tck_gen.sv
// Scan-clock divider: tck toggles every TCK_DIV clk cycles while run is high,
// with single-cycle rise/fall pulses marking the cycle in which tck toggles.
module cpu_debug_host_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic tck,
  output logic rise,
  output logic fall
);

  localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          wrap;

  // The toggle happens at the end of the cycle in which wrap is high, so the
  // pulses line up with the clk edge that moves tck.
  assign wrap = run && (cnt == CW'(TCK_DIV - 1));
  assign rise = wrap && !tck;
  assign fall = wrap && tck;

  // Divider counter and tck register; both parked at zero when not running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (!run) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (wrap) begin
      // NOTE: non-blocking assignments keep every register reading the
      // pre-edge values, independent of statement order.
      cnt <= '0;
      tck <= ~tck;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/cpu_debug_host_scan.sv
// Host-side virtual-JTAG scan engine: turns IR/DR scan commands into the
// vji_* strobe/tck sequence for the Nios II debug slave and returns the
// captured DR data and IR status on a response handshake.
module cpu_debug_host_scan
  import cpu_debug_host_scan_pkg::*;
#(
  parameter int TCK_DIV    = 2,
  parameter int DR_W       = DR_W_DEF,
  parameter int IR_W       = IR_W_DEF,
  parameter int RTI_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [IR_W-1:0] cmd_ir,
  input  logic            cmd_ir_only,
  input  logic [DR_W-1:0] cmd_dr,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DR_W-1:0] rsp_dr,
  output logic [IR_W-1:0] rsp_ir_out,
  output logic            vji_tck,
  output logic            vji_tdi,
  input  logic            vji_tdo,
  output logic [IR_W-1:0] vji_ir_in,
  input  logic [IR_W-1:0] vji_ir_out,
  output logic            vji_uir,
  output logic            vji_cdr,
  output logic            vji_sdr,
  output logic            vji_udr,
  output logic            vji_rti
);

  localparam int BW = (DR_W > 1) ? $clog2(DR_W) : 1;
  localparam int RW = (RTI_CYCLES > 1) ? $clog2(RTI_CYCLES) : 1;

  scan_state_e     state, state_n;
  logic [DR_W-1:0] shift_q, shift_nxt, capture_q;
  logic [BW-1:0]   bit_cnt;
  logic [RW-1:0]   rti_cnt;
  logic            ir_only_q;
  logic            tck_rise, tck_fall;
  logic            accept, bit_last, rti_last;

  assign cmd_ready = (state == ST_IDLE) && !rsp_valid;
  assign accept    = cmd_valid && cmd_ready;
  assign bit_last  = (bit_cnt == BW'(DR_W - 1));
  assign rti_last  = (rti_cnt == RW'(RTI_CYCLES - 1));
  assign shift_nxt = shift_q >> 1;

  // Strobes decode straight from the state register, so they are one-hot
  // (rti doubles as the idle indicator) and drop together on reset.
  assign vji_uir = (state == ST_UIR);
  assign vji_cdr = (state == ST_CDR);
  assign vji_sdr = (state == ST_SDR);
  assign vji_udr = (state == ST_UDR);
  assign vji_rti = (state == ST_IDLE) || (state == ST_RTI) || (state == ST_RSP);

  cpu_debug_host_tck_gen #(
    .TCK_DIV (TCK_DIV)
  ) u_tck_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (tck_running(state)),
    .tck     (vji_tck),
    .rise    (tck_rise),
    .fall    (tck_fall)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_n;
  end

  // Next-state logic: scan states advance only on a tck fall, so each one
  // spans whole tck periods (low phase then high phase).
  always_comb begin
    // NOTE: default first so every path assigns state_n and no latch is inferred.
    state_n = state;
    case (state)
      ST_IDLE: if (accept) state_n = ST_UIR;
      ST_UIR:  if (tck_fall) state_n = ir_only_q ? ST_RTI : ST_CDR;
      ST_CDR:  if (tck_fall) state_n = ST_SDR;
      ST_SDR:  if (tck_fall && bit_last) state_n = ST_UDR;
      ST_UDR:  if (tck_fall) state_n = ST_RTI;
      ST_RTI:  if (tck_fall && rti_last) state_n = ST_RSP;
      ST_RSP:  if (rsp_ready) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Datapath: command latch, tdi shift-out on falls, tdo capture on rises,
  // period counters and the response registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the shift/capture registers are reset as well, so an abandoned
      // scan can never leak stale data into a later response.
      shift_q    <= '0;
      capture_q  <= '0;
      bit_cnt    <= '0;
      rti_cnt    <= '0;
      ir_only_q  <= 1'b0;
      vji_tdi    <= 1'b0;
      vji_ir_in  <= '0;
      rsp_valid  <= 1'b0;
      rsp_dr     <= '0;
      rsp_ir_out <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            shift_q   <= cmd_dr;
            vji_ir_in <= cmd_ir;
            ir_only_q <= cmd_ir_only;
            bit_cnt   <= '0;
            rti_cnt   <= '0;
          end
        end
        ST_UIR: begin
          if (tck_rise) rsp_ir_out <= vji_ir_out;
        end
        ST_CDR: begin
          // First DR bit is presented for the whole first SDR period.
          if (tck_fall) vji_tdi <= shift_q[0];
        end
        ST_SDR: begin
          if (tck_rise) capture_q <= {vji_tdo, capture_q[DR_W-1:1]};
          if (tck_fall) begin
            // Zero fill means tdi returns low after the last bit.
            shift_q <= shift_nxt;
            vji_tdi <= shift_nxt[0];
            bit_cnt <= bit_last ? '0 : bit_cnt + BW'(1);
          end
        end
        ST_RTI: begin
          if (tck_fall) begin
            rti_cnt <= rti_last ? '0 : rti_cnt + RW'(1);
            if (rti_last) begin
              rsp_valid <= 1'b1;
              rsp_dr    <= ir_only_q ? '0 : capture_q;
            end
          end
        end
        ST_RSP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_debug_host_scan.sv
// Randomized self-checking bench: one default instance (TCK_DIV=2, DR_W=38)
// and one fast instance (TCK_DIV=1, DR_W=8), each driving a loopback slave
// model. Expected values come from the scan rules: the slave must receive the
// command DR, the host must return what the slave captured, with fixed latency.
module tb_cpu_debug_host_scan;
  import cpu_debug_host_scan_pkg::*;

  localparam int TD_P [2] = '{2, 1};
  localparam int DW_P [2] = '{38, 8};
  localparam int RTI_C    = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       cmd_valid = '0, cmd_ir_only = '0, rsp_ready = '0;
  logic [1:0]       cmd_ready, rsp_valid;
  logic [1:0][1:0]  cmd_ir = '0, ir_out = '0;
  logic [1:0][1:0]  rsp_ir_out, ir_in;
  logic [1:0][37:0] cmd_dr = '0, cap_val = '0;
  logic [1:0][37:0] rsp_dr, slave_dr;
  logic [1:0]       tck, tdi, uir, cdr, sdr, udr, rti;
  logic [1:0][31:0] n_uir, n_cdr, n_sdr, n_udr, n_rti;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int TD = (g == 0) ? 2 : 1;
    localparam int DW = (g == 0) ? 38 : 8;

    logic [DW-1:0] rsp_dr_l;
    logic [DW-1:0] sr = '0;
    logic [DW-1:0] got_l = '0;
    int cu = 0, cc = 0, cs = 0, cd = 0, cr = 0;
    logic prev_tck = 1'b0, prev_tdi = 1'b0, prev_rst = 1'b0;

    cpu_debug_host_scan #(
      .TCK_DIV (TD), .DR_W (DW), .IR_W (2), .RTI_CYCLES (RTI_C)
    ) u_dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .cmd_valid   (cmd_valid[g]),
      .cmd_ready   (cmd_ready[g]),
      .cmd_ir      (cmd_ir[g]),
      .cmd_ir_only (cmd_ir_only[g]),
      .cmd_dr      (cmd_dr[g][DW-1:0]),
      .rsp_valid   (rsp_valid[g]),
      .rsp_ready   (rsp_ready[g]),
      .rsp_dr      (rsp_dr_l),
      .rsp_ir_out  (rsp_ir_out[g]),
      .vji_tck     (tck[g]),
      .vji_tdi     (tdi[g]),
      .vji_tdo     (sr[0]),
      .vji_ir_in   (ir_in[g]),
      .vji_ir_out  (ir_out[g]),
      .vji_uir     (uir[g]),
      .vji_cdr     (cdr[g]),
      .vji_sdr     (sdr[g]),
      .vji_udr     (udr[g]),
      .vji_rti     (rti[g])
    );

    assign rsp_dr[g]   = 38'(rsp_dr_l);
    assign slave_dr[g] = 38'(got_l);
    assign n_uir[g] = cu;
    assign n_cdr[g] = cc;
    assign n_sdr[g] = cs;
    assign n_udr[g] = cd;
    assign n_rti[g] = cr;

    // Debug-slave model: loads capture data in CDR, shifts tdi in during SDR
    // (tdo = sr[0]), latches the shifted-in value in UDR; counts tck periods.
    always @(posedge tck[g]) begin
      if (cdr[g]) sr <= cap_val[g][DW-1:0];
      if (sdr[g]) sr <= {tdi[g], sr[DW-1:1]};
      if (udr[g]) got_l <= sr;
      if (uir[g]) cu <= cu + 1;
      if (cdr[g]) cc <= cc + 1;
      if (sdr[g]) cs <= cs + 1;
      if (udr[g]) cd <= cd + 1;
      if (rti[g]) cr <= cr + 1;
    end

    // Protocol monitor: tdi moves only on a tck fall; strobes one-hot.
    always @(negedge clk) begin
      if (reset_n && prev_rst) begin
        if (tdi[g] !== prev_tdi) check("tdi_only_at_fall", {prev_tck, tck[g]}, 2'b10);
        check("strobe_onehot", 64'($onehot0({uir[g], cdr[g], sdr[g], udr[g], rti[g]})), 1);
      end
      prev_tck <= tck[g];
      prev_tdi <= tdi[g];
      prev_rst <= reset_n;
    end
  end

  task automatic check_reset_outputs(input int s, input string tag);
    check({tag, "_tck"}, tck[s], 0);
    check({tag, "_tdi"}, tdi[s], 0);
    check({tag, "_strobes"}, {uir[s], cdr[s], sdr[s], udr[s], rti[s]}, 5'b00001);
    check({tag, "_ir_in"}, ir_in[s], 0);
    check({tag, "_cmd_ready"}, cmd_ready[s], 1);
    check({tag, "_rsp_valid"}, rsp_valid[s], 0);
    check({tag, "_rsp_dr"}, rsp_dr[s], 0);
    check({tag, "_rsp_ir_out"}, rsp_ir_out[s], 0);
  endtask

  // One command on instance s; hold = cycles of response backpressure.
  task automatic run_cmd(input int s, input logic [1:0] ir, input logic ir_only,
                         input logic [37:0] dr_in, input int hold);
    logic [37:0] mask, dr, cap, held;
    logic [1:0]  iro;
    int cyc, dw, td, exp_lat;
    logic [31:0] b_uir, b_cdr, b_sdr, b_udr, b_rti;
    dw   = DW_P[s];
    td   = TD_P[s];
    mask = (dw == 38) ? '1 : ((38'd1 << dw) - 38'd1);
    dr   = dr_in & mask;
    cap  = 38'({$urandom(), $urandom()}) & mask;
    iro  = 2'($urandom());
    cap_val[s] = cap;
    ir_out[s]  = iro;
    b_uir = n_uir[s]; b_cdr = n_cdr[s]; b_sdr = n_sdr[s]; b_udr = n_udr[s]; b_rti = n_rti[s];

    cyc = 0;
    while (!cmd_ready[s] && cyc < 50) begin @(negedge clk); cyc++; end
    check("cmd_ready_idle", cmd_ready[s], 1);
    cmd_ir[s] = ir; cmd_ir_only[s] = ir_only; cmd_dr[s] = dr; cmd_valid[s] = 1'b1;
    @(negedge clk);
    cmd_valid[s] = 1'b0;
    cyc = 1;
    check("cmd_ready_busy", cmd_ready[s], 0);
    while (!rsp_valid[s] && cyc < 1000) begin
      if (cyc == 2) begin
        // Stray handshakes while busy must have no effect.
        rsp_ready[s] = 1'b1;
        cmd_valid[s] = 1'b1; cmd_ir[s] = ~ir; cmd_dr[s] = ~dr; cmd_ir_only[s] = ~ir_only;
      end
      if (cyc == 3) begin rsp_ready[s] = 1'b0; cmd_valid[s] = 1'b0; end
      @(negedge clk);
      cyc++;
    end
    rsp_ready[s] = 1'b0; cmd_valid[s] = 1'b0;

    exp_lat = 2 * td * ((ir_only ? 1 : 3 + dw) + RTI_C) + 1;
    check("latency", cyc, exp_lat);
    check("rsp_dr", rsp_dr[s], ir_only ? 38'd0 : cap);
    check("rsp_ir_out", rsp_ir_out[s], iro);
    check("vji_ir_in", ir_in[s], ir);
    check("uir_periods", n_uir[s] - b_uir, 1);
    check("cdr_periods", n_cdr[s] - b_cdr, ir_only ? 0 : 1);
    check("sdr_periods", n_sdr[s] - b_sdr, ir_only ? 0 : dw);
    check("udr_periods", n_udr[s] - b_udr, ir_only ? 0 : 1);
    check("rti_periods", n_rti[s] - b_rti, RTI_C);
    if (!ir_only) check("slave_dr", slave_dr[s], dr);

    held = rsp_dr[s];
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", rsp_valid[s], 1);
      check("bp_rsp_dr", rsp_dr[s], held);
      check("bp_cmd_ready", cmd_ready[s], 0);
    end
    rsp_ready[s] = 1'b1;
    @(negedge clk);
    rsp_ready[s] = 1'b0;
    check("rsp_valid_clear", rsp_valid[s], 0);
    check("cmd_ready_back", cmd_ready[s], 1);
    repeat (2) @(negedge clk);
    check("no_extra_scan", n_uir[s] - b_uir, 1);
  endtask

  // Reset asserted in the middle of a DR scan on the default instance.
  task automatic reset_mid_scan();
    logic [31:0] b_sdr, b_udr;
    int cyc;
    cap_val[0] = 38'({$urandom(), $urandom()});
    b_sdr = n_sdr[0]; b_udr = n_udr[0];
    cmd_ir[0] = IR_OCIMEM; cmd_ir_only[0] = 1'b0;
    cmd_dr[0] = 38'({$urandom(), $urandom()}); cmd_valid[0] = 1'b1;
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    cyc = 0;
    while ((n_sdr[0] - b_sdr) < 17 && cyc < 1000) begin @(negedge clk); cyc++; end
    check("rst_sdr_bit", n_sdr[0] - b_sdr, 17);
    check("rst_in_sdr", sdr[0], 1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs(0, "rst_mid");
    repeat (3) @(negedge clk);
    check("rst_no_udr", n_udr[0] - b_udr, 0);
    check("rst_tck_held", tck[0], 0);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [37:0] d;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("reset_tck0", tck[0], 0);
      check("reset_tck1", tck[1], 0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_outputs(0, "por0");
    check_reset_outputs(1, "por1");

    run_cmd(0, IR_BREAK, 1'b0, 38'h2A_5A5A_5A5A, 0);
    run_cmd(0, IR_TRACE, 1'b1, 38'({$urandom(), $urandom()}), 0);
    run_cmd(0, IR_OCIMEM, 1'b0, 38'({$urandom(), $urandom()}), 20);
    reset_mid_scan();
    run_cmd(0, IR_OCIMEM_B, 1'b0, 38'({$urandom(), $urandom()}), 2);
    run_cmd(1, IR_BREAK, 1'b0, 38'hA5, 0);
    run_cmd(1, IR_TRACE, 1'b1, 38'h3C, 3);

    for (int i = 0; i < 10; i++) begin
      d = 38'({$urandom(), $urandom()});
      run_cmd($urandom_range(0, 1), 2'($urandom()), ($urandom_range(0, 3) == 0), d,
              $urandom_range(0, 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
